// File: rtl/a_and_b_pkg.sv
// Shared constants and helpers for the registered AND primitive.
// Operand widths up to MAX_W bits are supported by all_ones().
package a_and_b_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 64;

    // True when the low w bits of v are all ones.
    function automatic logic all_ones(
        input logic [MAX_W-1:0] v,
        input int               w
    );
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && !v[i]) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/a_and_b_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
// Sticks at all ones until cleared.
module a_and_b_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stop at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/a_and_b_core.sv
// Registered bitwise AND with valid and saturating all-ones count.
// Define A_AND_B_REDUCE_EN to add the registered q_all output.
module a_and_b_core
    import a_and_b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid_in,
    output logic [WIDTH-1:0] q,
    output logic             valid_out,
    output logic [CNT_W-1:0] hi_count
`ifdef A_AND_B_REDUCE_EN
    ,
    output logic             q_all
`endif
);

    logic [WIDTH-1:0] ab;
    logic [MAX_W-1:0] ab_ext;
    logic             ab_ones;
    logic             hit;

    assign ab      = a & b;
    assign ab_ext  = MAX_W'(ab);
    assign ab_ones = all_ones(ab_ext, WIDTH);
    assign hit     = valid_in && ab_ones;

    // Capture the AND result on accept; valid follows valid_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) q <= ab;
        end
    end

`ifdef A_AND_B_REDUCE_EN
    // Registered AND-reduction, updated alongside q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_all <= 1'b0;
        end else if (valid_in) begin
            q_all <= ab_ones;
        end
    end
`endif

    a_and_b_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .count (hi_count)
    );

endmodule

// File: tb/tb_a_and_b_core.sv
// Directed-vector bench for a_and_b_core.
// Four instances cover WIDTH=1/8/4 and a 2-bit saturating counter.
module tb_a_and_b_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // u1: WIDTH=1, CNT_W=8
    logic       r1 = 1'b1, a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       q1, vo1;
    logic [7:0] h1;
    // u2: WIDTH=1, CNT_W=2
    logic       r2 = 1'b1, a2 = 1'b0, b2 = 1'b0, v2 = 1'b0;
    logic       q2, vo2;
    logic [1:0] h2;
    // u3: WIDTH=8, CNT_W=8
    logic       r3 = 1'b1, v3 = 1'b0;
    logic [7:0] a3 = '0, b3 = '0;
    logic [7:0] q3;
    logic       vo3;
    logic [7:0] h3;
    // u4: WIDTH=4, CNT_W=8
    logic       r4 = 1'b1, v4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] q4;
    logic       vo4;
    logic [7:0] h4;
`ifdef A_AND_B_REDUCE_EN
    logic qa1, qa2, qa3, qa4;
`endif

    a_and_b_core #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(r1), .a(a1), .b(b1), .valid_in(v1),
        .q(q1), .valid_out(vo1), .hi_count(h1)
`ifdef A_AND_B_REDUCE_EN
        , .q_all(qa1)
`endif
    );

    a_and_b_core #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(r2), .a(a2), .b(b2), .valid_in(v2),
        .q(q2), .valid_out(vo2), .hi_count(h2)
`ifdef A_AND_B_REDUCE_EN
        , .q_all(qa2)
`endif
    );

    a_and_b_core #(.WIDTH(8), .CNT_W(8)) u3 (
        .clk(clk), .rst(r3), .a(a3), .b(b3), .valid_in(v3),
        .q(q3), .valid_out(vo3), .hi_count(h3)
`ifdef A_AND_B_REDUCE_EN
        , .q_all(qa3)
`endif
    );

    a_and_b_core #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(r4), .a(a4), .b(b4), .valid_in(v4),
        .q(q4), .valid_out(vo4), .hi_count(h4)
`ifdef A_AND_B_REDUCE_EN
        , .q_all(qa4)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset held two cycles with an active accept on the inputs.
        r1 = 1'b1; a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_q", 32'(q1), 32'd0);
            chk("rst_vo", 32'(vo1), 32'd0);
            chk("rst_hc", 32'(h1), 32'd0);
        end

        // WIDTH=1 truth table.
        r1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i][1];
            b1 = tt[i][0];
            v1 = 1'b1;
            tick();
            chk("tt_q", 32'(q1), 32'(tt[i][1] & tt[i][0]));
            chk("tt_vo", 32'(vo1), 32'd1);
        end
        chk("tt_hc", 32'(h1), 32'd1);

        // Hold: idle cycles, including X operands, keep q and count.
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                a1 = 1'bx;
                b1 = 1'bx;
            end
            tick();
            chk("hold_q", 32'(q1), 32'd1);
            chk("hold_vo", 32'(vo1), 32'd0);
            chk("hold_hc", 32'(h1), 32'd1);
        end

        // Saturation with CNT_W=2.
        r2 = 1'b0; a2 = 1'b1; b2 = 1'b1; v2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_hc", 32'(h2), 32'(sat[i]));
        end
        v2 = 1'b0;

        // WIDTH=8 partial overlap, then reset during an all-ones accept.
        r3 = 1'b0; a3 = 8'hF0; b3 = 8'h3C; v3 = 1'b1;
        tick();
        chk("w8_q", 32'(q3), 32'h30);
        chk("w8_vo", 32'(vo3), 32'd1);
        chk("w8_hc", 32'(h3), 32'd0);
        a3 = 8'hFF; b3 = 8'hFF; r3 = 1'b1;
        tick();
        chk("mrst_q", 32'(q3), 32'd0);
        chk("mrst_vo", 32'(vo3), 32'd0);
        chk("mrst_hc", 32'(h3), 32'd0);
        r3 = 1'b0;
        tick();
        chk("w8_ones_q", 32'(q3), 32'hFF);
        chk("w8_ones_hc", 32'(h3), 32'd1);
        v3 = 1'b0;

        // WIDTH=4 reduce checks.
        r4 = 1'b0; a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        tick();
        chk("w4_q_f", 32'(q4), 32'hF);
        chk("w4_hc_f", 32'(h4), 32'd1);
`ifdef A_AND_B_REDUCE_EN
        chk("qall_f", 32'(qa4), 32'd1);
`endif
        b4 = 4'hE;
        tick();
        chk("w4_q_e", 32'(q4), 32'hE);
        chk("w4_hc_e", 32'(h4), 32'd1);
`ifdef A_AND_B_REDUCE_EN
        chk("qall_e", 32'(qa4), 32'd0);
`endif
        v4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
